// File: rtl/video_ip_pkg.sv
// Shared definitions for the video frame gate: register map, control/status
// bit positions and the framing state machine encoding.
package video_ip_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_FRAME_LEN = 3'd2;
  localparam logic [2:0] ADDR_FRAME_CNT = 3'd3;
  localparam logic [2:0] ADDR_LAST_LEN  = 3'd4;
  localparam logic [2:0] ADDR_ERR_CNT   = 3'd5;

  localparam int CTRL_PAUSE   = 0;
  localparam int CTRL_IRQ_EOF = 1;
  localparam int CTRL_IRQ_ERR = 2;
  localparam int CTRL_DROP    = 3;

  localparam int ST_PAUSED   = 0;
  localparam int ST_EOF      = 1;
  localparam int ST_NOSOP    = 2;
  localparam int ST_EARLYSOP = 3;
  localparam int ST_LEN      = 4;
  localparam int ST_IN_FRAME = 5;

  typedef enum logic [1:0] {
    GAP    = 2'd0,
    FRAME  = 2'd1,
    PAUSED = 2'd2
  } gate_state_e;

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry registered output stage: the head entry drives the source port,
// the second entry catches the beat in flight when the sink stalls.
module st_skid_buffer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_space_next
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         w_pop;
  logic [1:0]   w_cnt_next;

  assign w_pop        = (r_cnt != 2'd0) && i_ready;
  assign w_cnt_next   = r_cnt + {1'b0, i_push} - {1'b0, w_pop};
  assign o_space_next = (w_cnt_next != 2'd2);
  assign o_valid      = (r_cnt != 2'd0);
  assign o_data       = r_head;

  // The head only changes when it is consumed or empty, so a stalled beat holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_skid <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_pop) begin
        if (r_cnt == 2'd2) begin
          r_head <= r_skid;
          if (i_push) r_skid <= i_data;
        end else if (i_push) begin
          r_head <= i_data;
        end
      end else if (i_push) begin
        if (r_cnt == 2'd0) r_head <= i_data;
        else               r_skid <= i_data;
      end
    end
  end

endmodule

// File: rtl/video_frame_gate.sv
// Frame-aware Avalon-ST gate: framing checks, frame-aligned pause/drop,
// frame statistics and an Avalon-MM register bank with maskable interrupt.
module video_frame_gate
  import video_ip_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PIX_CNT_W = 20,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              irq_sender,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out
);

  gate_state_e          r_state, w_state_next;
  logic                 r_pause, r_irq_eof, r_irq_err, r_drop;
  logic                 w_pause_next, w_irq_eof_next, w_irq_err_next, w_drop_next;
  logic                 r_eof, r_nosop, r_early, r_lenerr;
  logic                 w_eof_next, w_nosop_next, w_early_next, w_lenerr_next;
  logic [PIX_CNT_W-1:0] r_pix, w_pix_next, r_frame_len, r_last_len;
  logic [CNT_W-1:0]     r_frame_cnt, r_err_cnt, w_frame_cnt_next, w_err_cnt_next;
  logic [CNT_W:0]       w_frame_sum, w_err_sum;
  logic [CNT_W-1:0]     w_frame_base, w_err_base;
  logic [1:0]           w_err_inc;
  logic [5:0]           w_clr;
  logic                 r_ready, r_irq;
  logic [31:0]          r_readdata, w_rd_mux;
  logic                 w_wr, w_rd, w_acc, w_fwd, w_eof, w_nosop_ev, w_early_ev, w_len_ev;
  logic                 w_space_next, w_block, w_valid;
  logic [DATA_W+1:0]    w_out;

  assign w_wr  = chipselect && write;
  assign w_rd  = chipselect && read;
  assign w_acc = valid_in && r_ready;

  // Frame tracking: decides which accepted beats are forwarded and which events fire.
  always_comb begin
    w_state_next = r_state;
    w_fwd        = 1'b0;
    w_eof        = 1'b0;
    w_nosop_ev   = 1'b0;
    w_early_ev   = 1'b0;
    w_pix_next   = r_pix;
    case (r_state)
      GAP: begin
        if (r_pause) begin
          w_state_next = PAUSED;
        end else if (w_acc) begin
          if (startofpacket_in) begin
            w_fwd      = 1'b1;
            w_pix_next = PIX_CNT_W'(1);
            if (endofpacket_in) w_eof = 1'b1;
            else                w_state_next = FRAME;
          end else begin
            w_nosop_ev = 1'b1;
          end
        end
      end
      FRAME: begin
        if (w_acc) begin
          w_fwd = 1'b1;
          if (startofpacket_in) begin
            w_early_ev = 1'b1;
            w_pix_next = PIX_CNT_W'(1);
          end else if (r_pix != '1) begin
            w_pix_next = r_pix + PIX_CNT_W'(1);
          end
          if (endofpacket_in) begin
            w_eof        = 1'b1;
            w_state_next = r_pause ? PAUSED : GAP;
          end
        end
      end
      PAUSED: begin
        if (!r_pause) w_state_next = GAP;
      end
      default: w_state_next = GAP;
    endcase
    w_len_ev = w_eof && (r_frame_len != '0) && (w_pix_next != r_frame_len);
  end

  // Register-bank next values; hardware events win over same-cycle clears.
  always_comb begin
    w_pause_next   = r_pause;
    w_irq_eof_next = r_irq_eof;
    w_irq_err_next = r_irq_err;
    w_drop_next    = r_drop;
    if (w_wr && address == ADDR_CTRL) begin
      w_pause_next   = writedata[CTRL_PAUSE];
      w_irq_eof_next = writedata[CTRL_IRQ_EOF];
      w_irq_err_next = writedata[CTRL_IRQ_ERR];
      w_drop_next    = writedata[CTRL_DROP];
    end
    w_clr         = (w_wr && address == ADDR_STATUS) ? writedata[5:0] : 6'd0;
    w_eof_next    = (r_eof    && !w_clr[ST_EOF])      || w_eof;
    w_nosop_next  = (r_nosop  && !w_clr[ST_NOSOP])    || w_nosop_ev;
    w_early_next  = (r_early  && !w_clr[ST_EARLYSOP]) || w_early_ev;
    w_lenerr_next = (r_lenerr && !w_clr[ST_LEN])      || w_len_ev;
    w_frame_base     = (w_wr && address == ADDR_FRAME_CNT) ? '0 : r_frame_cnt;
    w_frame_sum      = {1'b0, w_frame_base} + (CNT_W+1)'(w_eof);
    w_frame_cnt_next = w_frame_sum[CNT_W] ? '1 : w_frame_sum[CNT_W-1:0];
    w_err_inc        = {1'b0, w_nosop_ev} + {1'b0, w_early_ev} + {1'b0, w_len_ev};
    w_err_base       = (w_wr && address == ADDR_ERR_CNT) ? '0 : r_err_cnt;
    w_err_sum        = {1'b0, w_err_base} + (CNT_W+1)'(w_err_inc);
    w_err_cnt_next   = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    w_block = (w_state_next == PAUSED) || (w_state_next == GAP && w_pause_next);
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_CTRL:      w_rd_mux[3:0] = {r_drop, r_irq_err, r_irq_eof, r_pause};
      ADDR_STATUS:    w_rd_mux[5:0] = {r_state == FRAME, r_lenerr, r_early, r_nosop,
                                       r_eof, r_state == PAUSED};
      ADDR_FRAME_LEN: w_rd_mux[PIX_CNT_W-1:0] = r_frame_len;
      ADDR_FRAME_CNT: w_rd_mux[CNT_W-1:0]     = r_frame_cnt;
      ADDR_LAST_LEN:  w_rd_mux[PIX_CNT_W-1:0] = r_last_len;
      ADDR_ERR_CNT:   w_rd_mux[CNT_W-1:0]     = r_err_cnt;
      default:        w_rd_mux = '0;
    endcase
  end

  // Ready and IRQ are registered from next-state values so they track without lag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= GAP;
      r_pause     <= 1'b0;
      r_irq_eof   <= 1'b0;
      r_irq_err   <= 1'b0;
      r_drop      <= 1'b0;
      r_eof       <= 1'b0;
      r_nosop     <= 1'b0;
      r_early     <= 1'b0;
      r_lenerr    <= 1'b0;
      r_pix       <= '0;
      r_frame_len <= '0;
      r_last_len  <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_ready     <= 1'b0;
      r_irq       <= 1'b0;
      r_readdata  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pause     <= w_pause_next;
      r_irq_eof   <= w_irq_eof_next;
      r_irq_err   <= w_irq_err_next;
      r_drop      <= w_drop_next;
      r_eof       <= w_eof_next;
      r_nosop     <= w_nosop_next;
      r_early     <= w_early_next;
      r_lenerr    <= w_lenerr_next;
      r_pix       <= w_pix_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_err_cnt   <= w_err_cnt_next;
      if (w_wr && address == ADDR_FRAME_LEN) r_frame_len <= writedata[PIX_CNT_W-1:0];
      if (w_eof) r_last_len <= w_pix_next;
      r_ready    <= w_block ? w_drop_next : w_space_next;
      r_irq      <= (w_eof_next && w_irq_eof_next) ||
                    ((w_nosop_next || w_early_next || w_lenerr_next) && w_irq_err_next);
      r_readdata <= w_rd ? w_rd_mux : 32'd0;
    end
  end

  st_skid_buffer #(.W(DATA_W + 2)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_fwd),
    .i_data       ({startofpacket_in, endofpacket_in, data_in}),
    .i_ready      (ready_in),
    .o_valid      (w_valid),
    .o_data       (w_out),
    .o_space_next (w_space_next)
  );

  assign valid_out         = w_valid;
  assign startofpacket_out = w_out[DATA_W+1];
  assign endofpacket_out   = w_out[DATA_W];
  assign data_out          = w_out[DATA_W-1:0];
  assign ready_out         = r_ready;
  assign irq_sender        = r_irq;
  assign readdata          = r_readdata;

endmodule

// File: tb/tb_video_frame_gate.sv
// Self-checking bench for video_frame_gate: a frame-level model predicts the
// forwarded beats and register contents; directed scenarios pin key values.
module tb_video_frame_gate;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        irq_sender;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [15:0] data_in = 16'd0;
  logic        sop_in = 1'b0;
  logic        eop_in = 1'b0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [15:0] data_out;
  logic        sop_out;
  logic        eop_out;

  int checkCount = 0;
  int passCount  = 0;
  int outCount   = 0;
  int readyMode  = 0;
  int outBefore  = 0;

  logic [17:0] expQ[$];

  bit mInFrame, mPaused, mPause, mIrqEof, mIrqErr, mDrop;
  bit mEof, mNosop, mEarly, mLenErr;
  int mPix, mFrameLen, mLastLen, mFrameCnt, mErrCnt;

  video_frame_gate dut (
    .clk               (clk),
    .reset             (reset),
    .chipselect        (chipselect),
    .address           (address),
    .write             (write),
    .writedata         (writedata),
    .read              (read),
    .readdata          (readdata),
    .irq_sender        (irq_sender),
    .valid_in          (valid_in),
    .ready_out         (ready_out),
    .data_in           (data_in),
    .startofpacket_in  (sop_in),
    .endofpacket_in    (eop_in),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .data_out          (data_out),
    .startofpacket_out (sop_out),
    .endofpacket_out   (eop_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [31:0] modelReg(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, mDrop, mIrqErr, mIrqEof, mPause};
      3'd1: return {26'd0, mInFrame, mLenErr, mEarly, mNosop, mEof, mPaused};
      3'd2: return 32'(mFrameLen);
      3'd3: return 32'(mFrameCnt);
      3'd4: return 32'(mLastLen);
      3'd5: return 32'(mErrCnt);
      default: return 32'd0;
    endcase
  endfunction

  // Frame-level model: applies the framing rules to every accepted beat and
  // the register side effects of every MM write, in edge order.
  initial forever begin : model
    bit acc, eof, nosop, early, lenErr;
    int errs;
    @(posedge clk or negedge reset);
    if (!reset) begin
      expQ.delete();
      mInFrame = 0; mPaused = 0; mPause = 0; mIrqEof = 0; mIrqErr = 0; mDrop = 0;
      mEof = 0; mNosop = 0; mEarly = 0; mLenErr = 0;
      mPix = 0; mFrameLen = 0; mLastLen = 0; mFrameCnt = 0; mErrCnt = 0;
    end else begin
      acc = valid_in && ready_out;
      eof = 0; nosop = 0; early = 0; lenErr = 0;
      if (mPaused) begin
        if (!mPause) mPaused = 0;
      end else if (!mInFrame) begin
        if (mPause) mPaused = 1;
        else if (acc) begin
          if (sop_in) begin
            expQ.push_back({sop_in, eop_in, data_in});
            mPix = 1;
            if (eop_in) eof = 1;
            else mInFrame = 1;
          end else nosop = 1;
        end
      end else if (acc) begin
        expQ.push_back({sop_in, eop_in, data_in});
        if (sop_in) begin early = 1; mPix = 1; end
        else mPix = mPix + 1;
        if (eop_in) begin eof = 1; mInFrame = 0; mPaused = mPause; end
      end
      lenErr = eof && (mFrameLen != 0) && (mPix != mFrameLen);
      if (chipselect && write) begin
        case (address)
          3'd0: begin
            mPause = writedata[0]; mIrqEof = writedata[1];
            mIrqErr = writedata[2]; mDrop = writedata[3];
          end
          3'd1: begin
            if (writedata[1]) mEof = 0;
            if (writedata[2]) mNosop = 0;
            if (writedata[3]) mEarly = 0;
            if (writedata[4]) mLenErr = 0;
          end
          3'd2: mFrameLen = int'(writedata[19:0]);
          3'd3: mFrameCnt = 0;
          3'd5: mErrCnt = 0;
          default: ;
        endcase
      end
      if (eof) begin
        mEof = 1; mLastLen = mPix;
        if (mFrameCnt < 65535) mFrameCnt = mFrameCnt + 1;
      end
      if (nosop) mNosop = 1;
      if (early) mEarly = 1;
      if (lenErr) mLenErr = 1;
      errs = int'(nosop) + int'(early) + int'(lenErr);
      mErrCnt = (mErrCnt + errs > 65535) ? 65535 : mErrCnt + errs;
    end
  end

  // Output compare: valid must track buffered beats, each beat must match the
  // model order and stay put while stalled, and a full buffer must deassert ready.
  initial forever begin : compare
    @(negedge clk);
    if (reset) begin
      checkOutput("validOut", 32'(valid_out), 32'(expQ.size() != 0));
      if (expQ.size() == 2 && !mDrop) checkOutput("fullReady", 32'(ready_out), 32'd0);
      if (valid_out && expQ.size() != 0) begin
        checkOutput("beat", {14'd0, sop_out, eop_out, data_out}, {14'd0, expQ[0]});
        if (ready_in) begin
          void'(expQ.pop_front());
          outCount++;
        end
      end
    end
  end

  initial begin : readyDriver
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0: ready_in = 1'b1;
        1: begin ready_in = pat[ph]; ph = (ph + 1) % 4; end
        default: ready_in = 1'b0;
      endcase
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic s, input logic e);
    int waitCycles;
    waitCycles = 0;
    valid_in = 1'b1; data_in = d; sop_in = s; eop_in = e;
    while (!ready_out && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!ready_out) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      valid_in = 1'b0;
    end else begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic sendFrame(input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++)
      applyStimulus(base + 16'(i), i == 0, i == len - 1);
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic checkReg(input string name, input logic [2:0] a, input logic [31:0] lit);
    logic [31:0] v;
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    v = readdata;
    checkOutput(name, v, lit);
    checkOutput({name, "Model"}, v, modelReg(a));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("resetData", 32'(data_out), 32'd0);
    checkOutput("resetCtl", {27'd0, valid_out, ready_out, sop_out, eop_out, irq_sender}, 32'd0);
    checkOutput("resetRead", readdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] scenario: 4x3 frame at full throughput");
    writeReg(3'd2, 32'd12);
    outBefore = outCount;
    sendFrame(16'h0100, 12);
    waitDrain();
    checkOutput("t1Beats", 32'(outCount - outBefore), 32'd12);
    checkReg("t1FrameCnt", 3'd3, 32'd1);
    checkReg("t1LastLen", 3'd4, 32'd12);
    checkReg("t1Status", 3'd1, 32'h02);
    checkReg("t1ErrCnt", 3'd5, 32'd0);

    $display("[TB] scenario: ready_in toggling mid-frame");
    writeReg(3'd1, 32'h1E);
    writeReg(3'd3, 32'd0);
    readyMode = 1;
    outBefore = outCount;
    sendFrame(16'h0200, 12);
    waitDrain();
    readyMode = 0;
    checkOutput("t2Beats", 32'(outCount - outBefore), 32'd12);
    checkReg("t2FrameCnt", 3'd3, 32'd1);

    $display("[TB] scenario: pause at pixel 5, no drop");
    writeReg(3'd1, 32'h1E);
    writeReg(3'd3, 32'd0);
    outBefore = outCount;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'h0300 + 16'(i), i == 0, i == 11);
      if (i == 4) writeReg(3'd0, 32'h1);
    end
    waitDrain();
    repeat (2) @(negedge clk);
    checkOutput("t3Beats", 32'(outCount - outBefore), 32'd12);
    checkOutput("t3PausedReady", 32'(ready_out), 32'd0);
    checkReg("t3Status", 3'd1, 32'h03);
    writeReg(3'd0, 32'h0);
    outBefore = outCount;
    sendFrame(16'h0380, 3);
    waitDrain();
    checkOutput("t3Resume", 32'(outCount - outBefore), 32'd3);
    checkReg("t3FrameCnt", 3'd3, 32'd2);
    checkReg("t3LastLen", 3'd4, 32'd3);

    $display("[TB] scenario: pause at pixel 5 with drop mode");
    writeReg(3'd1, 32'h1E);
    writeReg(3'd3, 32'd0);
    writeReg(3'd0, 32'h8);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'h0400 + 16'(i), i == 0, i == 11);
      if (i == 4) writeReg(3'd0, 32'h9);
    end
    waitDrain();
    repeat (2) @(negedge clk);
    checkOutput("t4DropReady", 32'(ready_out), 32'd1);
    checkReg("t4Status", 3'd1, 32'h03);
    outBefore = outCount;
    sendFrame(16'h0480, 4);
    sendFrame(16'h04C0, 4);
    repeat (3) @(negedge clk);
    checkOutput("t4Dropped", 32'(outCount - outBefore), 32'd0);
    checkReg("t4FrameCnt", 3'd3, 32'd1);
    checkReg("t4StatusAfter", 3'd1, 32'h03);
    writeReg(3'd0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] scenario: framing error injection");
    writeReg(3'd1, 32'h1E);
    writeReg(3'd3, 32'd0);
    writeReg(3'd5, 32'd0);
    writeReg(3'd0, 32'h4);
    sendFrame(16'h0500, 10);
    applyStimulus(16'h05AA, 1'b0, 1'b0);
    applyStimulus(16'h0560, 1'b1, 1'b0);
    applyStimulus(16'h0561, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      applyStimulus(16'h0570 + 16'(i), i == 0, i == 11);
    waitDrain();
    checkReg("t5ErrCnt", 3'd5, 32'd3);
    checkReg("t5Status", 3'd1, 32'h1E);
    checkReg("t5FrameCnt", 3'd3, 32'd2);
    checkReg("t5LastLen", 3'd4, 32'd12);
    checkOutput("t5IrqSet", 32'(irq_sender), 32'd1);
    writeReg(3'd1, 32'h1C);
    checkOutput("t5IrqClear", 32'(irq_sender), 32'd0);
    checkReg("t5StatusClr", 3'd1, 32'h02);

    $display("[TB] scenario: reset with full output stage");
    writeReg(3'd0, 32'h0);
    readyMode = 2;
    repeat (2) @(negedge clk);
    applyStimulus(16'h0600, 1'b1, 1'b0);
    applyStimulus(16'h0601, 1'b0, 1'b0);
    checkOutput("t6FullReady", 32'(ready_out), 32'd0);
    checkOutput("t6FullValid", 32'(valid_out), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6ResetData", 32'(data_out), 32'd0);
    checkOutput("t6ResetCtl", {27'd0, valid_out, ready_out, sop_out, eop_out, irq_sender}, 32'd0);
    readyMode = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    applyStimulus(16'h06AA, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkReg("t6Status", 3'd1, 32'h04);
    checkReg("t6ErrCnt", 3'd5, 32'd1);
    checkReg("t6Ctrl", 3'd0, 32'd0);
    checkReg("t6Unused", 3'd6, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
